// File: rtl/vscale_div_unit.sv
// Unpipelined 32-bit integer divider for the RISC-V M extension (DIV/DIVU/REM/REMU).
// One restoring shift-subtract step per cycle; divide-by-zero and signed overflow are answered at once.
module vscale_div_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_in_1,
    input  logic [31:0] req_in_2,
    input  logic        kill,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // req_op[1] selects remainder, req_op[0] selects unsigned.
    localparam logic [31:0] INT_MIN = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

    state_t      state_q, state_d;
    logic [4:0]  count_q;
    logic [1:0]  op_q;
    logic [31:0] divisor_q;
    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic        neg_quo_q;
    logic        neg_rem_q;

    logic        accept;
    logic        is_signed;
    logic        div_zero;
    logic        overflow;
    logic [31:0] mag_1;
    logic [31:0] mag_2;
    logic [32:0] rem_shift;
    logic        step_fits;
    logic [32:0] step_diff;

    assign req_ready = (state_q == S_IDLE) && !kill;
    assign accept    = req_valid && req_ready;

    assign is_signed = !req_op[0];
    assign div_zero  = (req_in_2 == 32'd0);
    assign overflow  = is_signed && (req_in_1 == INT_MIN) && (req_in_2 == ALL_ONES);
    assign mag_1     = (is_signed && req_in_1[31]) ? (~req_in_1 + 32'd1) : req_in_1;
    assign mag_2     = (is_signed && req_in_2[31]) ? (~req_in_2 + 32'd1) : req_in_2;

    // The shifted partial remainder needs a 33rd bit: the divisor may use all 32.
    assign rem_shift = {rem_q, quo_q[31]};
    assign step_fits = (rem_shift >= {1'b0, divisor_q});
    assign step_diff = rem_shift - {1'b0, divisor_q};

    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (kill) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        state_d = (div_zero || overflow) ? S_DONE : S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (count_q == 5'd31) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q   <= 5'd0;
            op_q      <= 2'd0;
            divisor_q <= 32'd0;
            quo_q     <= 32'd0;
            rem_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            op_q    <= req_op;
            count_q <= 5'd0;
            if (div_zero) begin
                divisor_q <= 32'd0;
                quo_q     <= ALL_ONES;
                rem_q     <= req_in_1;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
            end else if (overflow) begin
                divisor_q <= 32'd0;
                quo_q     <= INT_MIN;
                rem_q     <= 32'd0;
                neg_quo_q <= 1'b0;
                neg_rem_q <= 1'b0;
            end else begin
                // Quotient register starts as the dividend magnitude and is shifted out MSB first.
                divisor_q <= mag_2;
                quo_q     <= mag_1;
                rem_q     <= 32'd0;
                neg_quo_q <= is_signed && (req_in_1[31] ^ req_in_2[31]);
                neg_rem_q <= is_signed && req_in_1[31];
            end
        end else if ((state_q == S_COMPUTE) && !kill) begin
            count_q <= count_q + 5'd1;
            quo_q   <= {quo_q[30:0], step_fits};
            rem_q   <= step_fits ? step_diff[31:0] : rem_shift[31:0];
        end
    end

    always_comb begin
        resp_valid  = (state_q == S_DONE);
        resp_result = 32'd0;
        if (resp_valid) begin
            if (op_q[1]) begin
                resp_result = neg_rem_q ? (~rem_q + 32'd1) : rem_q;
            end else begin
                resp_result = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
            end
        end
    end

endmodule

// File: doc/vscale_div_unit.md
VSCALE_DIV_UNIT -- requirements
Module: vscale_div_unit

Interface
REQ-001 Parameters: none; datapath width SHALL be fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_op  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
REQ-007 req_in_1  input  32  dividend (ALU source A operand).
REQ-008 req_in_2  input  32  divisor (ALU source B operand).
REQ-009 kill  input  1  abort any in-flight or offered operation.
REQ-010 resp_valid  output  1  result available.
REQ-011 resp_ready  input  1  consumer takes result.
REQ-012 resp_result  output  32  quotient or remainder per req_op.

Function
REQ-013 The unit SHALL implement the states IDLE, COMPUTE and DONE.
REQ-014 req_ready SHALL equal (state == IDLE) && !kill.
REQ-015 A request SHALL be accepted on an edge where req_valid && req_ready; req_op, req_in_1 and req_in_2 SHALL be captured only at acceptance, and later changes SHALL be ignored.
REQ-016 Normal path: acceptance moves IDLE->COMPUTE, and a 5-bit counter is cleared.
- One restoring shift-subtract step SHALL occur per COMPUTE cycle.
- After the 32nd step, COMPUTE->DONE.
- resp_valid SHALL first be high in the 33rd cycle after the acceptance edge.
REQ-017 Signed ops (DIV, REM) SHALL divide operand magnitudes.
- Quotient SHALL be negated when the operand signs differ.
- Remainder SHALL take the sign of the dividend.
- Results SHALL be truncated toward zero, as for the RISC-V M extension.
REQ-018 Divide by zero (req_in_2 == 0) SHALL bypass COMPUTE (IDLE->DONE, resp_valid in the next cycle).
- Quotient result SHALL be 0xFFFFFFFF.
- Remainder result SHALL be req_in_1.
REQ-019 Signed overflow (DIV/REM, req_in_1 == 0x80000000, req_in_2 == 0xFFFFFFFF) SHALL bypass COMPUTE with 1-cycle latency.
- Quotient SHALL be 0x80000000.
- Remainder SHALL be 0.
REQ-020 In DONE, resp_valid SHALL be 1.
- resp_result SHALL hold stable until the edge where resp_ready is 1; that edge moves DONE->IDLE.
- resp_valid SHALL never be high outside DONE.
REQ-021 DONE with resp_ready low SHALL hold indefinitely, with no new acceptance.
REQ-022 kill high on any edge SHALL force state IDLE on that edge, discard partial or completed results, and produce no response.
- kill SHALL take priority over resp_ready and req_valid.
REQ-023 resp_result SHALL be 0 whenever resp_valid is 0.
REQ-024 The unit SHALL be fully unpipelined: at most one operation in flight; back-to-back acceptance is possible in the cycle after the DONE->IDLE edge.

Reset
REQ-025 While reset_n is 0, regardless of clk:
- state SHALL be IDLE.
- The counter, operand, quotient and remainder registers SHALL be 0.
- resp_valid SHALL be 0 and resp_result SHALL be 0.
REQ-026 In-flight operations SHALL be abandoned without response when reset_n asserts mid-operation.
REQ-027 req_ready SHALL be 1 on the first cycle after deassertion if kill is low.

Verification
REQ-028 DIVU 100/7, resp_ready=1 -> resp_valid exactly 33rd cycle after acceptance, resp_result=14.
REQ-029 REM 0xFFFFFFF9 (-7) by 2 -> resp_result=0xFFFFFFFF (-1); DIV same operands -> 0xFFFFFFFD (-3).
REQ-030 Special cases, each with resp_valid one cycle after acceptance:
- DIVU 5/0 -> 0xFFFFFFFF.
- REMU 5/0 -> 5.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
- REM of the same operands -> 0.
REQ-031 DIVU 1000/10 with kill pulsed 10 cycles after acceptance -> resp_valid never asserts, req_ready=1 next cycle, and the following DIVU 9/3 returns 3.
REQ-032 Result 14 with resp_ready held low 5 cycles -> resp_valid and resp_result=14 stable all 5 cycles, then IDLE after the resp_ready edge.
REQ-033 reset_n pulsed low asynchronously (between edges) 20 cycles into COMPUTE -> resp_valid=0 and resp_result=0 immediately, with no response after release.
